// File: rtl/count_seq_ctrl.sv
// Command sequencer for a WIDTH-bit terminal counter with pause and abort.
// Optional periodic reload mode is enabled by defining COUNT_SEQ_CTRL_RELOAD_EN.
module count_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_limit,
  input  logic             cmd_down,
`ifdef COUNT_SEQ_CTRL_RELOAD_EN
  input  logic             cmd_periodic,
`endif
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] ZERO_V = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);

  state_t           state_r, state_nxt_s;
  logic [WIDTH-1:0] count_r, count_nxt_s;
  logic [WIDTH-1:0] limit_r, limit_nxt_s;
  logic             down_r, down_nxt_s;
  logic             tc_r, tc_nxt_s;
  logic             busy_r, ready_r;
  logic             periodic_s, periodic_nxt_s;
  logic [WIDTH-1:0] terminal_s, start_s, stepped_s;

  // One count step toward the terminal value in the given direction.
  function automatic logic [WIDTH-1:0] step_val(input logic [WIDTH-1:0] v,
                                                input logic dn);
    if (dn) begin
      step_val = v - ONE_V;
    end else begin
      step_val = v + ONE_V;
    end
  endfunction

`ifdef COUNT_SEQ_CTRL_RELOAD_EN
  logic periodic_r;

  // Periodic flag register, latched with the command.
  always_ff @(posedge clock) begin
    if (reset) begin
      periodic_r <= 1'b0;
    end else begin
      periodic_r <= periodic_nxt_s;
    end
  end

  assign periodic_s = periodic_r;
`else
  assign periodic_s = 1'b0;
`endif

  assign terminal_s = down_r ? ZERO_V : limit_r;
  assign start_s    = down_r ? limit_r : ZERO_V;
  assign stepped_s  = step_val(count_r, down_r);

  // State and datapath register bank.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
      count_r <= ZERO_V;
      limit_r <= ZERO_V;
      down_r  <= 1'b0;
      tc_r    <= 1'b0;
      busy_r  <= 1'b0;
      ready_r <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      count_r <= count_nxt_s;
      limit_r <= limit_nxt_s;
      down_r  <= down_nxt_s;
      tc_r    <= tc_nxt_s;
      busy_r  <= (state_nxt_s != ST_IDLE);
      ready_r <= (state_nxt_s == ST_IDLE);
    end
  end

  // Next-state and datapath update; priority is abort over pause over step.
  always_comb begin
    state_nxt_s    = state_r;
    count_nxt_s    = count_r;
    limit_nxt_s    = limit_r;
    down_nxt_s     = down_r;
    tc_nxt_s       = 1'b0;
    periodic_nxt_s = periodic_s;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid) begin
          limit_nxt_s = cmd_limit;
          down_nxt_s  = cmd_down;
`ifdef COUNT_SEQ_CTRL_RELOAD_EN
          periodic_nxt_s = cmd_periodic;
`else
          periodic_nxt_s = 1'b0;
`endif
          if (cmd_limit == ZERO_V) begin
            // Zero limit is terminal immediately; periodic mode keeps running.
            count_nxt_s = ZERO_V;
            tc_nxt_s    = 1'b1;
            state_nxt_s = periodic_nxt_s ? ST_RUN : ST_DONE;
          end else begin
            count_nxt_s = cmd_down ? cmd_limit : ZERO_V;
            state_nxt_s = ST_RUN;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_nxt_s = ST_IDLE;
        end else if (pause) begin
          state_nxt_s = ST_HOLD;
        end else if (count_r == terminal_s) begin
          // Only reachable in periodic mode: reload the start value.
          if (periodic_s) begin
            count_nxt_s = start_s;
            tc_nxt_s    = (start_s == terminal_s);
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_DONE;
          end
        end else begin
          count_nxt_s = stepped_s;
          if (stepped_s == terminal_s) begin
            tc_nxt_s    = 1'b1;
            state_nxt_s = periodic_s ? ST_RUN : ST_DONE;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
      end
      ST_HOLD: begin
        if (abort) begin
          state_nxt_s = ST_IDLE;
        end else if (!pause) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        count_nxt_s = ZERO_V;
      end
    endcase
  end

  assign count     = count_r;
  assign tc        = tc_r;
  assign busy      = busy_r;
  assign cmd_ready = ready_r;

endmodule
